// File: rtl/div_tick_gen.sv
// ---------------------------------------------------------------------------
// div_tick_gen
//
// Consumes the two outputs of a 2-bit ripple-counter clock divider and turns
// them into clk-domain clock enables. The divided bits are asynchronous to
// clk, so each one passes through a SYNC_STAGES-deep synchroniser (legal
// range 2..4). Edges of the selected bit become single-cycle ticks. A small
// FSM aligns to the first tick after enabling, then counts ticks up to a
// programmable terminal value and pulses tc_pulse on each wrap.
//
// Optional build macro:
//   DIVTICK_BOTH_EDGE_EN  when defined, both edges of the selected bit
//                         produce a tick; otherwise rising edges only.
//
// Ports:
//   clk       system clock, all state on its rising edge
//   rst       asynchronous, active-high reset
//   div_in    divided-clock bits from the ripple counter (async to clk)
//   sel       0: use div_in[0], 1: use div_in[1]
//   en        count enable
//   clr       synchronous clear of counter and FSM
//   terminal  terminal count; tc_pulse fires every terminal+1 counted ticks
//   tick      one-cycle pulse per detected edge of the selected bit
//   tc_pulse  one-cycle pulse, the cycle after the wrapping tick
//   count     current tick count
//   running   high while the FSM is in RUN
// ---------------------------------------------------------------------------
module div_tick_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       div_in,
    input  logic             sel,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] terminal,
    output logic             tick,
    output logic             tc_pulse,
    output logic [CNT_W-1:0] count,
    output logic             running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Synchroniser chain: stage 0 samples div_in, the last stage is s_out.
    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  s_out;
    logic                        sel_q;
    logic                        selected_sync;
    logic                        prev;
    logic                        edge_hit;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             tc_nxt;

    assign s_out         = sync_q[SYNC_STAGES-1];
    assign selected_sync = s_out[sel_q];

`ifdef DIVTICK_BOTH_EDGE_EN
    assign edge_hit = selected_sync ^ prev;
`else
    assign edge_hit = selected_sync & ~prev;
`endif

    // NOTE: the synchroniser flops are reset like ordinary registers; a
    // chain that woke up with stale ones would emit a tick straight out of
    // reset, so every stage is cleared rather than left to power-up state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sel_q  <= 1'b0;
            prev   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its source, which is what lets the chain
            // below shift by exactly one stage per clock.
            sync_q[0] <= div_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sel_q <= sel;
            if (sel != sel_q) begin
                // Re-seed the edge history from the newly selected bit so
                // that a select change cannot look like an edge.
                prev <= s_out[sel];
                tick <= 1'b0;
            end else begin
                prev <= selected_sync;
                tick <= edge_hit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            tc_pulse <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            tc_pulse <= tc_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default before any branch,
        // so no path can leave a value unassigned and infer a latch.
        state_nxt = state;
        count_nxt = count;
        tc_nxt    = 1'b0;

        if (clr) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        // Alignment tick: starts the count but is not counted.
                        state_nxt = RUN;
                        count_nxt = '0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (tick) begin
                        // Equality only: a terminal lowered below the count
                        // lets the counter run up through all-ones and wrap.
                        if (count == terminal) begin
                            count_nxt = '0;
                            tc_nxt    = 1'b1;
                        end else begin
                            count_nxt = count + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign running = (state == RUN);

endmodule

// File: tb/tb_div_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_div_tick_gen
//
// Drives div_in from an ideal ripple counter whose source runs at clk/8
// (div_in[0] period 16 clk, div_in[1] period 32 clk). The driver knows when
// it creates an edge of the selected bit and pushes the cycle at which the
// tick must appear. Directed scenarios push the hand-computed count,
// tc_pulse and running values that must follow each tick. A monitor on the
// falling clock edge pops and compares both queues independently of the
// stimulus.
// ---------------------------------------------------------------------------
module tb_div_tick_gen;

    localparam int SS    = 2;
    localparam int CNT_W = 8;
`ifdef DIVTICK_BOTH_EDGE_EN
    localparam int EDGE_MULT = 2;
`else
    localparam int EDGE_MULT = 1;
`endif

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic             tc;
        logic             run;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [1:0]       div_in;
    logic             sel;
    logic             en;
    logic             clr;
    logic [CNT_W-1:0] terminal;
    logic             tick;
    logic             tc_pulse;
    logic [CNT_W-1:0] count;
    logic             running;

    div_tick_gen #(
        .SYNC_STAGES (SS),
        .CNT_W       (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .div_in   (div_in),
        .sel      (sel),
        .en       (en),
        .clr      (clr),
        .terminal (terminal),
        .tick     (tick),
        .tc_pulse (tc_pulse),
        .count    (count),
        .running  (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   ticks_seen = 0;
    int   tick_q[$];
    exp_t vals_q[$];
    exp_t idle_exp;
    logic idle_mode = 1'b0;
    exp_t post_exp;
    logic post_pending = 1'b0;

    logic [4:0] ph = '0;
    logic [1:0] old_div = 2'b00;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (post_pending) begin
            check("count_after_tick",   count,    post_exp.cnt);
            check("tc_after_tick",      tc_pulse, post_exp.tc);
            check("running_after_tick", running,  post_exp.run);
            post_pending = 1'b0;
        end else begin
            check("tc_quiet", tc_pulse, 0);
        end
        if (tick) begin
            ticks_seen++;
            if (tick_q.size() == 0) begin
                n_checks++;
                $display("FAIL tick_unexpected at cycle %0d: got tick=1, expected tick=0", cyc);
            end else begin
                check("tick_cycle", cyc, tick_q.pop_front());
            end
            if (vals_q.size() != 0) begin
                post_exp     = vals_q.pop_front();
                post_pending = 1'b1;
            end else if (idle_mode) begin
                post_exp     = idle_exp;
                post_pending = 1'b1;
            end else begin
                n_checks++;
                $display("FAIL tick_extra at cycle %0d: got a tick, expected none in this phase", cyc);
            end
        end
    end

    // Edge of the selected bit driven now -> sampled at the next posedge,
    // tick visible SS+1 posedges after that sample's predecessor.
    task automatic detect(input logic [1:0] nd);
`ifdef DIVTICK_BOTH_EDGE_EN
        if (nd[sel] != old_div[sel]) tick_q.push_back(cyc + 1 + SS);
`else
        if (nd[sel] && !old_div[sel]) tick_q.push_back(cyc + 1 + SS);
`endif
        old_div = nd;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        ph     = ph + 5'd1;
        div_in = ph[4:3];
        if (!rst) detect(ph[4:3]);
    endtask

    task automatic advance_to(input logic [4:0] target);
        int n = 0;
        while (ph != target && n < 64) begin
            step();
            n++;
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (ticks_seen < target && n < budget) begin
            step();
            n++;
        end
        check("ticks_reached", ticks_seen, target);
    endtask

    task automatic push_exp(input int cnt, input logic tc, input logic run);
        exp_t e;
        e.cnt = CNT_W'(cnt);
        e.tc  = tc;
        e.run = run;
        vals_q.push_back(e);
    endtask

    task automatic release_rst();
        rst     = 1'b0;
        old_div = 2'b00;
        detect(div_in);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        rst      = 1'b0;
        div_in   = 2'b00;
        sel      = 1'b0;
        en       = 1'b0;
        clr      = 1'b0;
        terminal = 8'd3;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tick",     tick,     0);
        check("rst_tc",       tc_pulse, 0);
        check("rst_count",    count,    0);
        check("rst_running",  running,  0);
        #1 release_rst();

        // Free-running ticks with en=0: no counting, no tc_pulse.
        idle_exp  = '{cnt: '0, tc: 1'b0, run: 1'b0};
        idle_mode = 1'b1;
        base = ticks_seen;
        repeat (68) step();
        check("idle_tick_count", ticks_seen - base, 4 * EDGE_MULT);

        // Counting with terminal=3: align, then 1,2,3,0(+tc),...
        idle_mode = 1'b0;
        en        = 1'b1;
        for (int i = 0; i < 8 * EDGE_MULT; i++) begin
            if (i == 0) push_exp(0, 1'b0, 1'b1);
            else        push_exp(i % 4, (i % 4) == 0, 1'b1);
        end
        repeat (128) step();
        check("count_phase_consumed", vals_q.size(), 0);

        // en low: IDLE, count held at 3. Switch to div_in[1] while it is 1
        // and div_in[0] is 0: no tick at the switch, period doubles.
        en        = 1'b0;
        idle_exp  = '{cnt: 8'd3, tc: 1'b0, run: 1'b0};
        idle_mode = 1'b1;
        advance_to(5'd22);
        sel  = 1'b1;
        base = ticks_seen;
        repeat (64) step();
        check("sel1_tick_count", ticks_seen - base, 2 * EDGE_MULT);

        // Back to div_in[0]; clear arriving together with a tick at count 2.
        sel       = 1'b0;
        idle_mode = 1'b0;
        en        = 1'b1;
        base      = ticks_seen;
        push_exp(0, 1'b0, 1'b1);
        push_exp(1, 1'b0, 1'b1);
        push_exp(2, 1'b0, 1'b1);
        push_exp(0, 1'b0, 1'b0);
        push_exp(0, 1'b0, 1'b1);
        push_exp(1, 1'b0, 1'b1);
        run_until(base + 4, 200);
        clr = 1'b1;
        step();
        clr = 1'b0;
        run_until(base + 6, 200);
        step();

        // Count up to 5, then async reset between clock edges.
        terminal = 8'd7;
        base     = ticks_seen;
        for (int c = 2; c <= 5; c++) push_exp(c, 1'b0, 1'b1);
        run_until(base + 4, 200);
        step();
        #2 rst = 1'b1;
        #1;
        check("async_rst_count",   count,    0);
        check("async_rst_tick",    tick,     0);
        check("async_rst_tc",      tc_pulse, 0);
        check("async_rst_running", running,  0);
        en        = 1'b0;
        idle_exp  = '{cnt: '0, tc: 1'b0, run: 1'b0};
        idle_mode = 1'b1;
        repeat (3) step();
        release_rst();
        repeat (20) step();

        // terminal=0: every counted tick wraps.
        idle_mode = 1'b0;
        en        = 1'b1;
        terminal  = 8'd0;
        base      = ticks_seen;
        push_exp(0, 1'b0, 1'b1);
        repeat (3) push_exp(0, 1'b1, 1'b1);
        run_until(base + 4, 200);
        step();

        // Terminal lowered below the count: run through 255, wrap, then
        // count to the new terminal.
        clr = 1'b1;
        step();
        clr      = 1'b0;
        terminal = 8'd7;
        base     = ticks_seen;
        for (int c = 0; c <= 3; c++) push_exp(c, 1'b0, 1'b1);
        run_until(base + 4, 200);
        step();
        terminal = 8'd2;
        base     = ticks_seen;
        for (int c = 4; c <= 255; c++) push_exp(c, 1'b0, 1'b1);
        push_exp(0, 1'b0, 1'b1);
        push_exp(1, 1'b0, 1'b1);
        push_exp(2, 1'b0, 1'b1);
        push_exp(0, 1'b1, 1'b1);
        run_until(base + 256, 256 * 20);
        step();

        check("tick_queue_empty", tick_q.size(), 0);
        check("vals_queue_empty", vals_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/div_tick_gen.md
Name: div_tick_gen

Overview:
- Downstream consumer of the 2-bit ripple-counter clock-divider outputs.
- Brings the divided clock bits, which are asynchronous to clk because they are ripple-derived, into the clk domain through a synchroniser.
- Converts edges of the selected divided bit into single-cycle clk-domain ticks.
- Counts those ticks up to a programmable terminal value, so later logic uses clock enables instead of derived clocks.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per div_in bit (legal range 2..4).
- CNT_W, 8, width of tick counter and terminal value.

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- div_in  input  2  divided-clock bits from the ripple counter; asynchronous to clk.
- sel  input  1  0 selects div_in[0] (clk/2 of source), 1 selects div_in[1] (clk/4 of source).
- en  input  1  count enable.
- clr  input  1  synchronous clear of counter and FSM.
- terminal  input  CNT_W  terminal count; tc_pulse fires every terminal+1 counted ticks.
- tick  output  1  one-cycle pulse per detected edge of the selected bit.
- tc_pulse  output  1  one-cycle pulse when count wraps.
- count  output  CNT_W  current tick count.
- running  output  1  high while FSM is in RUN.

Behaviour:
- Reset values:
  - all synchroniser flops, the edge-history flop prev and the registered select sel_q are 0;
  - tick=0, tc_pulse=0, count=0, running=0;
  - FSM = IDLE.
- Synchroniser:
  - each div_in bit passes through SYNC_STAGES flops; s_out is the last stage.
  - sel is registered into sel_q; the selected synchronised bit is selected_sync = s_out[sel_q].
- Edge detect and latency:
  - tick is registered: tick <= selected_sync & ~prev, and prev <= selected_sync, every cycle.
  - a div_in rise first sampled at edge N sets tick after edge N+SYNC_STAGES; tick is high for exactly 1 cycle.
  - tick is generated regardless of en and FSM state.
- Select change:
  - in the cycle where sel != sel_q, prev is loaded with the newly selected synchronised bit and tick is forced to 0.
  - a select change therefore never produces a spurious tick.
- FSM, evaluated in priority order:
  1. clr=1 (any state) -> IDLE; count <= 0; tc_pulse <= 0.
  2. IDLE: en=1 -> WAIT.
  3. WAIT: en=0 -> IDLE. Otherwise tick=1 -> RUN, count <= 0. This alignment tick is not counted.
  4. RUN: en=0 -> IDLE with count held. Otherwise, on tick=1: if count==terminal, count <= 0 and tc_pulse <= 1; else count <= count+1.
- running = (state==RUN).
- tc_pulse is high for 1 cycle, the cycle after the wrapping tick. It is 0 in all other cases.
- Terminal and wrap rules:
  - terminal=0: tc_pulse follows every counted tick.
  - terminal is sampled at each tick. If terminal is lowered below the current count, count increments to 2^CNT_W-1, wraps to 0, and continues counting up to the new terminal.
- Simultaneous events:
  - clr with tick: clr wins, the tick is not counted.
  - en falling with tick: the tick is not counted.
- rst asserted mid-operation returns every register to its reset value immediately, regardless of clk.

Optional Feature:
- Macro DIVTICK_BOTH_EDGE_EN.
- Defined: tick <= selected_sync ^ prev, so both edges of the selected bit tick. The count rate doubles; same latency, FSM and sel-change suppression.
- Undefined: rising edges only, as above.

Test Plan:
- Reset release, then div_in toggled by an ideal ripple counter with source = clk/8, sel=0, en=0 -> tick once per 16 clk cycles; count=0; running=0; tc_pulse never set.
- en=1, terminal=3, sel=0 -> first tick moves FSM WAIT->RUN with count=0. Subsequent ticks give count 1,2,3,0. tc_pulse is high exactly 1 cycle after the tick taking count 3->0, then repeats every 4 ticks.
- div_in[0] rising edge sampled at edge 10, SYNC_STAGES=2 -> tick high only in the cycle after edge 12.
- Switch sel 0->1 while div_in[1]=1 and div_in[0]=0 -> no tick in the switch cycle. The next tick arrives only on the following rise of div_in[1]. Tick period doubles versus sel=0.
- In RUN with count=2, assert clr together with a tick -> count=0, tc_pulse=0, running=0, FSM IDLE. With en still 1, FSM enters WAIT and the next tick re-aligns.
- Assert rst asynchronously between clk edges while count=5 -> count, tick, tc_pulse and running are 0 immediately. With DIVTICK_BOTH_EDGE_EN defined, re-running the first scenario gives ticks every 8 clk cycles.
